bram_port_arbiter: RTL and testbench

- Shares one simple-dual-port BRAM (`sdp_bram`: write port A, synchronous read port B) between two requesters. Default geometry is 9-bit data, 2048 words, 11-bit address.
- Each requester issues single-word read or write transactions through a req/gnt handshake.
- Writes and reads are arbitrated independently. A write from one requester and a read from the other can therefore issue in the same cycle.
- The block registers all BRAM strobes, tracks the read latency, returns read data to the owning requester, and forwards write data on a same-cycle address collision.

---
 rtl/bram_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Brief    : Two-requester arbiter sharing one simple-dual-port BRAM, with
//            independent write/read arbitration and write-first bypass.
// Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
    parameter int DWIDTH = 9,
    parameter int DEPTH  = 2048,
    parameter int AWIDTH = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata0,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] rdata,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [AWIDTH-1:0] bram_addra,
    output logic [DWIDTH-1:0] bram_dla,
    output logic              bram_enb,
    output logic [AWIDTH-1:0] bram_addrb,
    input  logic [DWIDTH-1:0] bram_dob
);

    // Reject geometries the address bus cannot reach.
    if (DEPTH > (1 << AWIDTH)) begin : g_depth_overflow
        $error("bram_port_arbiter: DEPTH exceeds 2**AWIDTH");
    end

    logic              r_wprio;
    logic              r_rprio;
    logic              w_wcand0;
    logic              w_wcand1;
    logic              w_rcand0;
    logic              w_rcand1;
    logic              w_wgnt0;
    logic              w_wgnt1;
    logic              w_rgnt0;
    logic              w_rgnt1;
    logic              w_wgnt_any;
    logic              w_rgnt_any;
    logic [AWIDTH-1:0] w_waddr;
    logic [DWIDTH-1:0] w_wdata;
    logic [AWIDTH-1:0] w_raddr;
    logic              w_collide;
    logic              r_rtag;
    logic              r_rvalid;
    logic              r_rowner;
    logic              r_byp;
    logic [DWIDTH-1:0] r_byp_data;
    logic [DWIDTH-1:0] r_rdata_hold;
    logic [DWIDTH-1:0] w_rsel;

    // Write and read classes arbitrate independently; on contention the
    // priority bit names the winner, and any grant hands priority to the other.
    always_comb begin
        w_wcand0   = req0 & we0;
        w_wcand1   = req1 & we1;
        w_rcand0   = req0 & ~we0;
        w_rcand1   = req1 & ~we1;
        w_wgnt0    = rst_n & w_wcand0 & (~w_wcand1 | ~r_wprio);
        w_wgnt1    = rst_n & w_wcand1 & (~w_wcand0 |  r_wprio);
        w_rgnt0    = rst_n & w_rcand0 & (~w_rcand1 | ~r_rprio);
        w_rgnt1    = rst_n & w_rcand1 & (~w_rcand0 |  r_rprio);
        w_wgnt_any = w_wgnt0 | w_wgnt1;
        w_rgnt_any = w_rgnt0 | w_rgnt1;
        w_waddr    = w_wgnt1 ? addr1  : addr0;
        w_wdata    = w_wgnt1 ? wdata1 : wdata0;
        w_raddr    = w_rgnt1 ? addr1  : addr0;
    end

    assign gnt0 = w_wgnt0 | w_rgnt0;
    assign gnt1 = w_wgnt1 | w_rgnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wprio <= 1'b0;
            r_rprio <= 1'b0;
        end else begin
            if (w_wgnt_any) begin
                r_wprio <= ~w_wgnt1;
            end
            if (w_rgnt_any) begin
                r_rprio <= ~w_rgnt1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_ena   <= 1'b0;
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dla   <= '0;
        end else begin
            bram_ena <= w_wgnt_any;
            bram_wea <= w_wgnt_any;
            if (w_wgnt_any) begin
                bram_addra <= w_waddr;
                bram_dla   <= w_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_enb   <= 1'b0;
            bram_addrb <= '0;
            r_rtag     <= 1'b0;
        end else begin
            bram_enb <= w_rgnt_any;
            if (w_rgnt_any) begin
                bram_addrb <= w_raddr;
                r_rtag     <= w_rgnt1;
            end
        end
    end

    // BRAM is read-first on a same-address write; capture the new word instead.
    assign w_collide = bram_ena & bram_wea & bram_enb & (bram_addra == bram_addrb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid   <= 1'b0;
            r_rowner   <= 1'b0;
            r_byp      <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_rvalid <= bram_enb;
            r_rowner <= r_rtag;
            r_byp    <= w_collide;
            if (w_collide) begin
                r_byp_data <= bram_dla;
            end
        end
    end

    always_comb begin
        w_rsel = r_byp ? r_byp_data : bram_dob;
        rdata  = r_rvalid ? w_rsel : r_rdata_hold;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_hold <= '0;
        end else if (r_rvalid) begin
            r_rdata_hold <= w_rsel;
        end
    end

    assign rvalid0 = r_rvalid & ~r_rowner;
    assign rvalid1 = r_rvalid &  r_rowner;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_arbiter
// Brief    : Directed self-checking bench for bram_port_arbiter with a
//            behavioural read-first simple-dual-port BRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;
    localparam int DW = 9;
    localparam int AW = 11;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          bram_ena, bram_wea, bram_enb;
    logic [AW-1:0] bram_addra, bram_addrb;
    logic [DW-1:0] bram_dla, bram_dob;
    logic [DW-1:0] mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.DWIDTH(DW), .DEPTH(DEPTH), .AWIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
        .bram_dla(bram_dla), .bram_enb(bram_enb), .bram_addrb(bram_addrb),
        .bram_dob(bram_dob)
    );

    // Read-first BRAM: a same-edge write is not visible on dob.
    always @(posedge clk) begin
        if (bram_ena && bram_wea) mem[bram_addra] <= bram_dla;
        if (bram_enb) bram_dob <= mem[bram_addrb];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic drive(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(p, 1'b1, a, d);
        #3;
        check("wr_gnt", (p == 0) ? gnt0 : gnt1, 1);
        tick();
        idle();
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        drive(p, 1'b0, a, '0);
        #3;
        check("rd_gnt", (p == 0) ? gnt0 : gnt1, 1);
        tick();
        idle();
        #3;
        check("rd_enb_t1", bram_enb, 1);
        check("rd_early_valid", rvalid0 | rvalid1, 0);
        tick();
        #3;
        check("rd_valid", (p == 0) ? rvalid0 : rvalid1, 1);
        check("rd_other_valid", (p == 0) ? rvalid1 : rvalid0, 0);
        check("rd_data", rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1 (run ended)");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1;
        #3;
        check("rst_gnt0", gnt0, 0);
        check("rst_strobes", {bram_ena, bram_wea, bram_enb}, 0);
        check("rst_addr", {bram_addra, bram_addrb}, 0);
        check("rst_dla", bram_dla, 0);
        check("rst_rvalid", {rvalid0, rvalid1}, 0);
        check("rst_rdata", rdata, 0);
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        // Single write then read
        drive(0, 1'b1, 11'd0, 9'd125);
        #3;
        check("t1_gnt0", gnt0, 1);
        check("t1_gnt1", gnt1, 0);
        tick();
        idle();
        #3;
        check("t1_ena_wea", {bram_ena, bram_wea}, 2'b11);
        check("t1_addra", bram_addra, 0);
        check("t1_dla", bram_dla, 125);
        tick();
        #3;
        check("t1_ena_off", {bram_ena, bram_wea}, 0);
        check("t1_dla_hold", bram_dla, 125);
        rd(0, 11'd0, 9'd125);

        // Write contention and alternation
        do_reset();
        drive(0, 1'b1, 11'd5, 9'd10);
        drive(1, 1'b1, 11'd6, 9'd20);
        #3;
        check("t2_c1_gnt0", gnt0, 1);
        check("t2_c1_gnt1", gnt1, 0);
        tick();
        req0 = 1'b0;
        #3;
        check("t2_c2_gnt1", gnt1, 1);
        check("t2_c2_gnt0", gnt0, 0);
        tick();
        drive(0, 1'b1, 11'd7, 9'd30);
        drive(1, 1'b1, 11'd8, 9'd40);
        #3;
        check("t2_c3_gnt0", gnt0, 1);
        check("t2_c3_gnt1", gnt1, 0);
        tick();
        drive(0, 1'b1, 11'd10, 9'd50);
        #3;
        check("t2_c4_gnt1", gnt1, 1);
        check("t2_c4_gnt0", gnt0, 0);
        tick();
        req1 = 1'b0;
        #3;
        check("t2_c5_gnt0", gnt0, 1);
        tick();
        idle();
        tick();
        rd(0, 11'd5, 9'd10);
        rd(1, 11'd6, 9'd20);
        rd(0, 11'd7, 9'd30);
        rd(1, 11'd8, 9'd40);
        rd(0, 11'd10, 9'd50);

        // Write on one port, read on the other, same cycle
        wr(1, 11'd4, 9'd99);
        drive(0, 1'b1, 11'd3, 9'd7);
        drive(1, 1'b0, 11'd4, 9'd0);
        #3;
        check("t3_gnt_both", {gnt0, gnt1}, 2'b11);
        tick();
        idle();
        #3;
        check("t3_ena_enb", {bram_ena, bram_enb}, 2'b11);
        check("t3_addra", bram_addra, 3);
        check("t3_addrb", bram_addrb, 4);
        tick();
        #3;
        check("t3_rvalid1", rvalid1, 1);
        check("t3_rvalid0", rvalid0, 0);
        check("t3_rdata", rdata, 99);
        rd(0, 11'd3, 9'd7);

        // Same-address write and read: bypass
        wr(0, 11'd9, 9'd1);
        drive(0, 1'b1, 11'd9, 9'd300);
        drive(1, 1'b0, 11'd9, 9'd0);
        #3;
        check("t4_gnt_both", {gnt0, gnt1}, 2'b11);
        tick();
        idle();
        tick();
        #3;
        check("t4_rvalid1", rvalid1, 1);
        check("t4_bypass", rdata, 300);
        tick();
        #3;
        check("t4_rvalid_off", rvalid1, 0);
        check("t4_rdata_hold", rdata, 300);
        rd(1, 11'd9, 9'd300);

        // Back-to-back reads
        wr(0, 11'd1, 9'd11);
        wr(0, 11'd2, 9'd22);
        drive(1, 1'b0, 11'd0, 9'd0);
        #3;
        check("t5_g0", gnt1, 1);
        tick();
        addr1 = 11'd1;
        #3;
        check("t5_g1", gnt1, 1);
        check("t5_v_early", rvalid1, 0);
        tick();
        addr1 = 11'd2;
        #3;
        check("t5_g2", gnt1, 1);
        check("t5_v0", rvalid1, 1);
        check("t5_d0", rdata, 125);
        tick();
        idle();
        #3;
        check("t5_v1", rvalid1, 1);
        check("t5_d1", rdata, 11);
        tick();
        #3;
        check("t5_v2", rvalid1, 1);
        check("t5_d2", rdata, 22);
        tick();
        #3;
        check("t5_v_end", rvalid1, 0);
        check("t5_hold", rdata, 22);

        // Reset in the middle of a read
        wr(0, 11'd20, 9'd5);
        rd(0, 11'd0, 9'd125);
        drive(0, 1'b0, 11'd0, 9'd0);
        #3;
        check("t6_gnt0", gnt0, 1);
        tick();
        rst_n = 1'b0;
        #3;
        check("t6_rst_enb", bram_enb, 0);
        check("t6_rst_gnt0", gnt0, 0);
        tick();
        #3;
        check("t6_rst_rvalid", {rvalid0, rvalid1}, 0);
        idle();
        tick();
        rst_n = 1'b1;
        #3;
        check("t6_rel_rvalid", {rvalid0, rvalid1}, 0);
        check("t6_rel_strobes", {bram_ena, bram_wea, bram_enb}, 0);
        tick();
        #3;
        check("t6_rel_rvalid2", {rvalid0, rvalid1}, 0);
        drive(0, 1'b0, 11'd1, 9'd0);
        drive(1, 1'b0, 11'd2, 9'd0);
        #3;
        check("t6_rprio_gnt", {gnt0, gnt1}, 2'b10);
        tick();
        req0 = 1'b0;
        #3;
        check("t6_rprio_gnt1", gnt1, 1);
        tick();
        idle();
        drive(0, 1'b1, 11'd30, 9'd1);
        drive(1, 1'b1, 11'd31, 9'd2);
        #3;
        check("t6_wprio_gnt", {gnt0, gnt1}, 2'b10);
        tick();
        idle();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
